// File: rtl/alu_unit_pkg.sv
// Shared op-code defines and result record for the integer ALU issue port.
// The RS, ROB and ALU all take their op names from here.
package alu_unit_pkg;

   typedef enum logic [5:0] {
      NOP, LUI, AUIPC, JAL, JALR,
      BEQ, BNE, BLT, BGE, BLTU, BGEU,
      LB, LH, LW, LBU, LHU, SB, SH, SW,
      ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
      ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND
   } op_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] result;
      logic        jump;
      logic [31:0] target;
   } core_out_t;

endpackage

// File: rtl/alu_unit_if.sv
// Issue port from the reservation station, flush input from the ROB,
// and the CDB/ROB result broadcast back out.
interface alu_unit_if import alu_unit_pkg::*; ();

   op_t         inst_name_from_rs;
   logic [31:0] V1_from_rs;
   logic [31:0] V2_from_rs;
   logic [31:0] pc_from_rs;
   logic [31:0] imm_from_rs;
   logic [4:0]  rob_id_from_rs;
   logic        rollback_flag_from_rob;

   logic        valid_to_cdb;
   logic [31:0] result_to_cdb;
   logic [4:0]  rob_id_to_cdb;
   logic        jump_flag_to_rob;
   logic [31:0] target_pc_to_rob;

   modport master (
      output inst_name_from_rs, V1_from_rs, V2_from_rs, pc_from_rs, imm_from_rs,
             rob_id_from_rs, rollback_flag_from_rob,
      input  valid_to_cdb, result_to_cdb, rob_id_to_cdb, jump_flag_to_rob,
             target_pc_to_rob
   );

   modport slave (
      input  inst_name_from_rs, V1_from_rs, V2_from_rs, pc_from_rs, imm_from_rs,
             rob_id_from_rs, rollback_flag_from_rob,
      output valid_to_cdb, result_to_cdb, rob_id_to_cdb, jump_flag_to_rob,
             target_pc_to_rob
   );

endinterface

// File: rtl/alu_unit_core.sv
// Purely combinational ALU: rd value, branch/jump resolution and an
// issue-valid flag (clear for NOP and memory ops, which belong to the LSB).
module alu_core import alu_unit_pkg::*; (
   input  op_t         op,
   input  logic [31:0] v1,
   input  logic [31:0] v2,
   input  logic [31:0] pc,
   input  logic [31:0] imm,
   output core_out_t   res
);

   logic [31:0] pc4;
   logic [31:0] pc_imm;
   logic [31:0] jalr_sum;
   logic [4:0]  sh_r;
   logic [4:0]  sh_i;
   logic        take;

   assign pc4      = pc + 32'd4;
   assign pc_imm   = pc + imm;
   assign jalr_sum = v1 + imm;
   assign sh_r     = v2[4:0];
   assign sh_i     = imm[4:0];

   always_comb begin
      res        = '0;
      res.valid  = 1'b1;
      res.target = pc4;
      take       = 1'b0;
      case (op)
         ADD:   res.result = v1 + v2;
         SUB:   res.result = v1 - v2;
         AND:   res.result = v1 & v2;
         OR:    res.result = v1 | v2;
         XOR:   res.result = v1 ^ v2;
         SLL:   res.result = v1 << sh_r;
         SRL:   res.result = v1 >> sh_r;
         SRA:   res.result = $signed(v1) >>> sh_r;
         SLT:   res.result = {31'd0, $signed(v1) < $signed(v2)};
         SLTU:  res.result = {31'd0, v1 < v2};
         ADDI:  res.result = v1 + imm;
         ANDI:  res.result = v1 & imm;
         ORI:   res.result = v1 | imm;
         XORI:  res.result = v1 ^ imm;
         SLLI:  res.result = v1 << sh_i;
         SRLI:  res.result = v1 >> sh_i;
         SRAI:  res.result = $signed(v1) >>> sh_i;
         SLTI:  res.result = {31'd0, $signed(v1) < $signed(imm)};
         SLTIU: res.result = {31'd0, v1 < imm};
         LUI:   res.result = imm;
         AUIPC: res.result = pc_imm;
         JAL: begin
            res.result = pc4;
            res.jump   = 1'b1;
            res.target = pc_imm;
         end
         JALR: begin
            res.result = pc4;
            res.jump   = 1'b1;
            res.target = {jalr_sum[31:1], 1'b0};
         end
         BEQ, BNE, BLT, BGE, BLTU, BGEU: begin
            case (op)
               BEQ:     take = (v1 == v2);
               BNE:     take = (v1 != v2);
               BLT:     take = ($signed(v1) <  $signed(v2));
               BGE:     take = ($signed(v1) >= $signed(v2));
               BLTU:    take = (v1 <  v2);
               default: take = (v1 >= v2);
            endcase
            res.jump   = take;
            res.target = take ? pc_imm : pc4;
         end
         // NOP and loads/stores: nothing to broadcast
         default: res.valid = 1'b0;
      endcase
   end

endmodule

// File: rtl/alu_unit.sv
// ALU execution unit: one registered stage after alu_core. Flush and reset
// act even while rdy_in is low; otherwise a low rdy_in freezes everything.
module alu_unit import alu_unit_pkg::*; (
   input  logic     clk_in,
   input  logic     rst_in,
   input  logic     rdy_in,
   alu_unit_if.slave bus
);

   core_out_t nxt;

   alu_core u_core (
      .op  (bus.inst_name_from_rs),
      .v1  (bus.V1_from_rs),
      .v2  (bus.V2_from_rs),
      .pc  (bus.pc_from_rs),
      .imm (bus.imm_from_rs),
      .res (nxt)
   );

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         bus.valid_to_cdb     <= 1'b0;
         bus.result_to_cdb    <= '0;
         bus.rob_id_to_cdb    <= '0;
         bus.jump_flag_to_rob <= 1'b0;
         bus.target_pc_to_rob <= '0;
      end else if (bus.rollback_flag_from_rob) begin
         // only the strobe is killed; the payload is don't-care once invalid
         bus.valid_to_cdb <= 1'b0;
      end else if (rdy_in) begin
         bus.valid_to_cdb     <= nxt.valid;
         bus.result_to_cdb    <= nxt.result;
         bus.rob_id_to_cdb    <= bus.rob_id_from_rs;
         bus.jump_flag_to_rob <= nxt.jump;
         bus.target_pc_to_rob <= nxt.target;
      end
   end

endmodule

// File: tb/tb_alu_unit.sv
// Directed bench for alu_unit: reference model of the ALU semantics checked
// every cycle, plus hand-computed literal expectations for key vectors.
module tb_alu_unit;
   import alu_unit_pkg::*;

   logic clk, rst, rdy;
   alu_unit_if bus();

   alu_unit dut (
      .clk_in (clk),
      .rst_in (rst),
      .rdy_in (rdy),
      .bus    (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   // reference semantics written straight from the ISA rules
   function automatic void model(input op_t op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] pc, input logic [31:0] imm,
                                 output logic v, output logic [31:0] r,
                                 output logic j, output logic [31:0] t);
      int signed sa, sb, si;
      sa = a; sb = b; si = imm;
      v = 1'b1; r = 0; j = 1'b0; t = pc + 4;
      case (op)
         ADD:   r = a + b;
         SUB:   r = a - b;
         AND:   r = a & b;
         OR:    r = a | b;
         XOR:   r = a ^ b;
         SLL:   r = a << (b % 32);
         SRL:   r = a >> (b % 32);
         SRA:   r = sa >>> (b % 32);
         SLT:   r = (sa < sb) ? 1 : 0;
         SLTU:  r = (a < b) ? 1 : 0;
         ADDI:  r = a + imm;
         ANDI:  r = a & imm;
         ORI:   r = a | imm;
         XORI:  r = a ^ imm;
         SLLI:  r = a << (imm % 32);
         SRLI:  r = a >> (imm % 32);
         SRAI:  r = sa >>> (imm % 32);
         SLTI:  r = (sa < si) ? 1 : 0;
         SLTIU: r = (a < imm) ? 1 : 0;
         LUI:   r = imm;
         AUIPC: r = pc + imm;
         JAL:   begin r = pc + 4; j = 1'b1; t = pc + imm; end
         JALR:  begin r = pc + 4; j = 1'b1; t = (a + imm) & 32'hFFFF_FFFE; end
         BEQ:   j = (a == b);
         BNE:   j = (a != b);
         BLT:   j = (sa < sb);
         BGE:   j = (sa >= sb);
         BLTU:  j = (a < b);
         BGEU:  j = (a >= b);
         default: v = 1'b0;
      endcase
      if (op inside {BEQ, BNE, BLT, BGE, BLTU, BGEU} && j) t = pc + imm;
   endfunction

   logic        e_v, m_v, e_j, m_j;
   logic [31:0] e_r, m_r, e_t, m_t;
   logic [4:0]  e_id;

   always @(posedge clk) begin
      model(bus.inst_name_from_rs, bus.V1_from_rs, bus.V2_from_rs, bus.pc_from_rs,
            bus.imm_from_rs, m_v, m_r, m_j, m_t);
      if (rst) begin
         e_v <= 0; e_r <= 0; e_j <= 0; e_t <= 0; e_id <= 0;
      end else if (bus.rollback_flag_from_rob) begin
         e_v <= 0;
      end else if (rdy) begin
         e_v <= m_v; e_r <= m_r; e_j <= m_j; e_t <= m_t; e_id <= bus.rob_id_from_rs;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("mdl_valid", 32'(bus.valid_to_cdb), 32'(e_v));
         if (e_v) begin
            chk("mdl_result", bus.result_to_cdb, e_r);
            chk("mdl_rob_id", 32'(bus.rob_id_to_cdb), 32'(e_id));
            chk("mdl_jump", 32'(bus.jump_flag_to_rob), 32'(e_j));
            chk("mdl_target", bus.target_pc_to_rob, e_t);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input op_t op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] pc, input logic [31:0] imm, input logic [4:0] id);
      bus.inst_name_from_rs = op;
      bus.V1_from_rs        = a;
      bus.V2_from_rs        = b;
      bus.pc_from_rs        = pc;
      bus.imm_from_rs       = imm;
      bus.rob_id_from_rs    = id;
   endtask

   task automatic nop();
      issue(NOP, 0, 0, 0, 0, 0);
   endtask

   initial begin
      rst = 1'b1; rdy = 1'b1;
      bus.rollback_flag_from_rob = 1'b0;
      nop();
      step(); step();
      chk("rst_valid",  32'(bus.valid_to_cdb), 0);
      chk("rst_result", bus.result_to_cdb, 0);
      chk("rst_rob_id", 32'(bus.rob_id_to_cdb), 0);
      chk("rst_jump",   32'(bus.jump_flag_to_rob), 0);
      chk("rst_target", bus.target_pc_to_rob, 0);
      rst = 1'b0;
      chk_en = 1'b1;

      issue(ADD, 5, 7, 32'h10, 0, 3); step();
      chk("add_valid", 32'(bus.valid_to_cdb), 1);
      chk("add_result", bus.result_to_cdb, 12);
      chk("add_rob_id", 32'(bus.rob_id_to_cdb), 3);
      chk("add_jump", 32'(bus.jump_flag_to_rob), 0);
      chk("add_target", bus.target_pc_to_rob, 32'h14);
      nop(); step();
      chk("add_oneshot", 32'(bus.valid_to_cdb), 0);

      issue(SRA, 32'h8000_0000, 33, 0, 0, 1); step();
      chk("sra_result", bus.result_to_cdb, 32'hC000_0000);
      issue(SRLI, 32'h8000_0000, 0, 0, 1, 2); step();
      chk("srli_result", bus.result_to_cdb, 32'h4000_0000);
      chk("srli_b2b_valid", 32'(bus.valid_to_cdb), 1);

      issue(BLT, 32'hFFFF_FFFF, 1, 32'h100, 32'h20, 4); step();
      chk("blt_jump", 32'(bus.jump_flag_to_rob), 1);
      chk("blt_target", bus.target_pc_to_rob, 32'h120);
      chk("blt_result", bus.result_to_cdb, 0);
      issue(BLTU, 32'hFFFF_FFFF, 1, 32'h100, 32'h20, 5); step();
      chk("bltu_jump", 32'(bus.jump_flag_to_rob), 0);
      chk("bltu_target", bus.target_pc_to_rob, 32'h104);

      issue(JALR, 32'h1001, 0, 32'h200, 4, 6); step();
      chk("jalr_result", bus.result_to_cdb, 32'h204);
      chk("jalr_jump", 32'(bus.jump_flag_to_rob), 1);
      chk("jalr_target", bus.target_pc_to_rob, 32'h1004);

      issue(ADD, 1, 2, 0, 0, 8); bus.rollback_flag_from_rob = 1'b1; step();
      chk("rollback_kill", 32'(bus.valid_to_cdb), 0);
      bus.rollback_flag_from_rob = 1'b0;
      issue(SUB, 10, 3, 0, 0, 7); step();
      chk("post_rb_valid", 32'(bus.valid_to_cdb), 1);
      chk("post_rb_result", bus.result_to_cdb, 7);
      chk("post_rb_rob_id", 32'(bus.rob_id_to_cdb), 7);

      issue(XOR, 32'hF0, 32'hFF, 0, 0, 9); step();
      rdy = 1'b0;
      issue(ADD, 100, 200, 0, 0, 2);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_valid", 32'(bus.valid_to_cdb), 1);
         chk("stall_result", bus.result_to_cdb, 32'h0F);
         chk("stall_rob_id", 32'(bus.rob_id_to_cdb), 9);
      end
      rdy = 1'b1; nop(); step();
      chk("stall_release", 32'(bus.valid_to_cdb), 0);

      issue(LUI, 0, 0, 32'h40, 32'h1234_5000, 10); step();
      chk("lui_result", bus.result_to_cdb, 32'h1234_5000);
      chk("lui_target", bus.target_pc_to_rob, 32'h44);
      issue(AUIPC, 0, 0, 32'h1000, 32'h2000, 11); step();
      chk("auipc_result", bus.result_to_cdb, 32'h3000);
      issue(JAL, 0, 0, 32'h40, 32'h100, 12); step();
      chk("jal_result", bus.result_to_cdb, 32'h44);
      chk("jal_target", bus.target_pc_to_rob, 32'h140);
      issue(SLTI, 32'hFFFF_FFFB, 0, 0, 3, 13); step();
      chk("slti_result", bus.result_to_cdb, 1);
      issue(SLTIU, 32'hFFFF_FFFB, 0, 0, 3, 14); step();
      chk("sltiu_result", bus.result_to_cdb, 0);
      issue(SLL, 1, 32'h21, 0, 0, 15); step();
      chk("sll_result", bus.result_to_cdb, 2);
      issue(LW, 1, 2, 0, 0, 16); step();
      chk("lw_no_valid", 32'(bus.valid_to_cdb), 0);

      issue(ADD, 1, 1, 0, 0, 4); rst = 1'b1; step();
      chk("midrst_valid", 32'(bus.valid_to_cdb), 0);
      chk("midrst_result", bus.result_to_cdb, 0);
      rst = 1'b0; nop(); step();
      chk("post_rst_valid", 32'(bus.valid_to_cdb), 0);
      issue(ADDI, 1, 0, 0, 32'hFFFF_FFFF, 5); step();
      chk("post_rst_addi", bus.result_to_cdb, 0);
      chk("post_rst_addi_v", 32'(bus.valid_to_cdb), 1);

      for (int i = 0; i < 60; i++) begin
         issue(op_t'(6'($urandom_range(0, 37))), $urandom, $urandom,
               $urandom & 32'hFFFF_FFFC, $urandom, 5'($urandom));
         rdy = ($urandom_range(0, 4) != 0);
         bus.rollback_flag_from_rob = ($urandom_range(0, 9) == 0);
         step();
      end
      rdy = 1'b1; bus.rollback_flag_from_rob = 1'b0; nop(); step(); step();

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
